// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
// Double-buffered scan controller for common-anode 7-segment displays.
// Values are staged on a load strobe and copied into the display
// registers only at a frame boundary, so a scan never mixes two updates.
//
// Parameters:
//   DIGITS   number of scanned digits (2..8), digit 0 is rightmost
//   DIV_W    prescaler width, each digit slot lasts 2^DIV_W clocks (>= 3)
//   BLINK_W  blink counter width in frames (blink build only)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                strobe capturing vals/dp_in/blink_mask into staging
//   vals[4*DIGITS]      hex value per digit, digit i at [4i+3:4i]
//   dp_in[DIGITS]       decimal point per digit, 1 = lit
//   blink_mask[DIGITS]  1 = digit blinks (blink build only)
//   lz_blank            live: suppress leading zeros
//   bright[3]           live: on-time is (bright+1)/8 of each slot
//   seg[7]              {g,f,e,d,c,b,a}, active low, registered
//   dp                  decimal point, active low, registered
//   an[DIGITS]          anode enables, active low one-hot, registered
//   pending             staged data waits for commit
//   frame_done          one-cycle pulse after each full scan
//
// Build option: define SSD_BLINK_EN to build the per-digit blink feature.

module ssd_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int DIV_W   = 16,
  parameter int BLINK_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   vals,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  input  logic [2:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  stg_vals_q, stg_vals_d, disp_vals_q, disp_vals_d;
  logic [DIGITS-1:0]       stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       an_q, an_d;

  logic                    slot_end, boundary, commit, pwm_on, blink_off, digit_blank;
  logic [DIGITS-1:0]       digit_zero, lz_hide;

  assign slot_end = &pre_q;
  assign boundary = slot_end && (idx_q == LAST_IDX);
  assign commit   = boundary && pending_q;
  // Top three prescaler bits form an 8-step PWM ramp within each slot.
  assign pwm_on   = (pre_q[DIV_W-1 -: 3] <= bright);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
    assign digit_zero[gi] = (disp_vals_q[gi] == 4'h0);
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  // Digit 0 always shows, so a value of zero still displays "0".
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_hide  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && digit_zero[k];
      lz_hide[k] = lz_blank && all_zero;
    end
  end

`ifdef SSD_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DIGITS-1:0]  stg_blink_q, stg_blink_d, disp_blink_q, disp_blink_d;

  assign blink_cnt_d  = boundary ? blink_cnt_q + 1'b1 : blink_cnt_q;
  assign stg_blink_d  = load ? blink_mask : stg_blink_q;
  assign disp_blink_d = commit ? stg_blink_q : disp_blink_q;
  assign blink_off    = blink_cnt_q[BLINK_W-1] && disp_blink_q[idx_q];
`else
  logic unused_blink;
  localparam int UNUSED_BLINK_W = BLINK_W;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    // Staging takes a new load even on the commit edge; display then
    // receives the previously staged data and pending stays set.
    stg_vals_d   = load ? vals : stg_vals_q;
    stg_dp_d     = load ? dp_in : stg_dp_q;
    disp_vals_d  = commit ? stg_vals_q : disp_vals_q;
    disp_dp_d    = commit ? stg_dp_q : disp_dp_q;
    pending_d    = load || (pending_q && !boundary);
    frame_done_d = boundary;

    digit_blank = lz_hide[idx_q] || blink_off || !pwm_on;
    if (digit_blank) begin
      seg_d = 7'h7f;
      dp_d  = 1'b1;
      an_d  = '1;
    end else begin
      seg_d = seg_decode(disp_vals_q[idx_q]);
      dp_d  = ~disp_dp_q[idx_q];
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      stg_vals_q   <= '0;
      stg_dp_q     <= '0;
      disp_vals_q  <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= 7'h7f;
      dp_q         <= 1'b1;
      an_q         <= '1;
`ifdef SSD_BLINK_EN
      blink_cnt_q  <= '0;
      stg_blink_q  <= '0;
      disp_blink_q <= '0;
`endif
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      stg_vals_q   <= stg_vals_d;
      stg_dp_q     <= stg_dp_d;
      disp_vals_q  <= disp_vals_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
`ifdef SSD_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
      stg_blink_q  <= stg_blink_d;
      disp_blink_q <= disp_blink_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with DIGITS=4, DIV_W=4 (16-clock slots,
// 64-clock frames) plus a free-running DIGITS=5 instance for the wrap check.
// The reference model tracks time as a cycle count since reset and derives
// slot, digit, frame and blink phase from it arithmetically.

module tb_ssd_scan_ctrl;

  localparam int BLINK_W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] vals = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  logic [6:0]  seg5;
  logic        dp5;
  logic [4:0]  an5;
  logic        pending5;
  logic        frame_done5;
  logic        load5 = 1'b0;
  logic [19:0] vals5 = '0;
  logic [4:0]  dp_in5 = '0;
  logic [4:0]  blink_mask5 = '0;
  logic        lz_blank5 = 1'b0;
  logic [2:0]  bright5 = 3'd7;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.DIGITS(4), .DIV_W(4), .BLINK_W(BLINK_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .vals(vals), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .pending(pending), .frame_done(frame_done)
  );

  ssd_scan_ctrl #(.DIGITS(5), .DIV_W(4), .BLINK_W(BLINK_W)) dut5 (
    .clk(clk), .rst_n(rst_n), .load(load5), .vals(vals5), .dp_in(dp_in5),
    .blink_mask(blink_mask5), .lz_blank(lz_blank5), .bright(bright5),
    .seg(seg5), .dp(dp5), .an(an5), .pending(pending5), .frame_done(frame_done5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  // ---------------- reference model ----------------
  int          m_cyc = 0;
  logic [15:0] m_stg_v = '0, m_disp_v = '0;
  logic [3:0]  m_stg_dp = '0, m_disp_dp = '0, m_stg_bm = '0, m_disp_bm = '0;
  bit          m_pend = 0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7f;
  logic        exp_dp = 1'b1, exp_pend = 1'b0, exp_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  pre, idx, frames;
    bit  dark, allz;
    if (!rst_n) begin
      m_cyc = 0; m_pend = 0;
      m_stg_v = '0; m_disp_v = '0; m_stg_dp = '0; m_disp_dp = '0;
      m_stg_bm = '0; m_disp_bm = '0;
      exp_an = 4'hF; exp_seg = 7'h7f; exp_dp = 1'b1; exp_pend = 1'b0; exp_fd = 1'b0;
    end else begin
      pre    = m_cyc % 16;
      idx    = (m_cyc / 16) % 4;
      frames = m_cyc / 64;
      dark   = (pre / 2) > int'(bright);
      if (lz_blank && idx != 0) begin
        allz = 1;
        for (int j = idx; j < 4; j++) if (m_disp_v[4*j +: 4] != 4'h0) allz = 0;
        if (allz) dark = 1;
      end
`ifdef SSD_BLINK_EN
      if ((frames % (1 << BLINK_W)) >= (1 << (BLINK_W - 1)) && m_disp_bm[idx]) dark = 1;
`endif
      exp_seg = dark ? 7'h7f : dec(m_disp_v[4*idx +: 4]);
      exp_an  = dark ? 4'hF : ~(4'b0001 << idx);
      exp_dp  = dark ? 1'b1 : ~m_disp_dp[idx];
      exp_fd  = (m_cyc % 64) == 63;
      if (exp_fd && m_pend) begin
        m_disp_v = m_stg_v; m_disp_dp = m_stg_dp; m_disp_bm = m_stg_bm; m_pend = 0;
      end
      if (load) begin
        m_stg_v = vals; m_stg_dp = dp_in; m_stg_bm = blink_mask; m_pend = 1;
      end
      exp_pend = m_pend;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("an", an, exp_an);
      chk("seg", seg, exp_seg);
      chk("dp", dp, exp_dp);
      chk("pending", pending, exp_pend);
      chk("frame_done", frame_done, exp_fd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edges(input int n);
    int guard = 0;
    while (m_cyc < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cyc < n) chk("wait_timeout", m_cyc, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_pend", pending, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
    wait_edges(e - 1);
    #1 load = 1'b1; vals = v; dp_in = d; blink_mask = bm;
    $display("load at edge %0d vals=%h dp=%b blink=%b", e, v, d, bm);
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    #1 rst_n = 1'b1;

    // Scan rotation and frame period after reset release.
    wait_edges(1);   chk("first_an", an, 4'b1110); chk("first_seg", seg, 7'b1000000);
    wait_edges(17);  chk("rot_an1", an, 4'b1101);
    wait_edges(33);  chk("rot_an2", an, 4'b1011);
    wait_edges(49);  chk("rot_an3", an, 4'b0111);
    wait_edges(63);  chk("fd_before", frame_done, 1'b0);
    wait_edges(64);  chk("fd_pulse", frame_done, 1'b1); chk("fd5_not4", frame_done5, 1'b0);
    wait_edges(65);  chk("an5_idx4", an5, 5'b01111);
    wait_edges(79);  chk("fd5_before", frame_done5, 1'b0);
    wait_edges(80);  chk("fd5_pulse", frame_done5, 1'b1);
    wait_edges(81);  chk("an5_wrap", an5, 5'b11110); chk("fd5_end", frame_done5, 1'b0);
    wait_edges(160); chk("fd5_pulse2", frame_done5, 1'b1);

    // 0x00A5 with leading-zero blanking.
    do_reset();
    lz_blank = 1'b1; bright = 3'd7;
    do_load(2, 16'h00A5, 4'b0000, 4'b0000);
    wait_edges(3);   chk("a5_pend", pending, 1'b1);
    wait_edges(63);  chk("a5_pend_hold", pending, 1'b1);
    wait_edges(64);  chk("a5_pend_clr", pending, 1'b0);
    wait_edges(65);  chk("a5_d0_seg", seg, 7'b0010010); chk("a5_d0_an", an, 4'b1110);
    wait_edges(81);  chk("a5_d1_seg", seg, 7'b0001000); chk("a5_d1_an", an, 4'b1101);
    wait_edges(97);  chk("a5_d2_an", an, 4'b1111);
    wait_edges(113); chk("a5_d3_an", an, 4'b1111);

    // Last load wins; a load on the commit edge stays pending.
    do_reset();
    lz_blank = 1'b0;
    do_load(10, 16'h1234, 4'b0000, 4'b0000);
    do_load(30, 16'h5678, 4'b0010, 4'b0000);
    do_load(64, 16'h9ABC, 4'b0000, 4'b0000);
    chk("edge_load_pend", pending, 1'b1);
    wait_edges(65);  chk("last_d0", seg, 7'b0000000);
    wait_edges(81);  chk("last_d1_dp", dp, 1'b0);
    wait_edges(113); chk("last_d3", seg, 7'b0010010);
    wait_edges(129); chk("next_d0", seg, 7'b1000110); chk("next_pend", pending, 1'b0);

    // Brightness duty.
    do_reset();
    bright = 3'd0;
    wait_edges(16);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); if (an != 4'hF) cnt++; end
    chk("duty_b0", cnt, 2);
    #1 bright = 3'd7;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); if (an != 4'hF) cnt++; end
    chk("duty_b7", cnt, 16);

    // Blink on digit 0 across frames 1..4.
    do_reset();
    do_load(2, 16'h1111, 4'b0000, 4'b0001);
    wait_edges(64);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (an == 4'b1110) cnt++; end
`ifdef SSD_BLINK_EN
    chk("blink_d0_lit", cnt, 32);
`else
    chk("blink_d0_lit", cnt, 64);
`endif

    // Randomized traffic with occasional mid-frame resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      load = ($urandom % 24) == 0;
      case ($urandom % 4)
        0: vals = 16'($urandom);
        1: vals = 16'($urandom) & 16'h00FF;
        2: vals = 16'($urandom) & 16'h000F;
        default: vals = 16'h0000;
      endcase
      dp_in = 4'($urandom);
      blink_mask = 4'($urandom);
      if (load) $display("load at edge %0d vals=%h dp=%b blink=%b", m_cyc + 1, vals, dp_in, blink_mask);
      if (($urandom % 200) == 0) lz_blank = ~lz_blank;
      if (($urandom % 150) == 0) bright = 3'($urandom);
      if (($urandom % 1500) == 0) begin
        rst_n = 1'b0;
        $display("reset at edge %0d", m_cyc);
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised, double-buffered multiplexer for common-anode 7-segment displays. It drives DIGITS digits with full hex decode, per-digit decimal points, leading-zero blanking, PWM brightness and optional per-digit blink. New values are staged on a `load` strobe and committed only at a frame boundary, so a digit never shows half of one update and half of the next. It sits between score/status logic and the board's segment/anode pins.

## Interface
- DIGITS, 4, number of digits scanned (2..8); digit 0 is rightmost.
- DIV_W, 16, prescaler width; each digit slot lasts 2^DIV_W clocks (DIV_W >= 3).
- BLINK_W, 6, blink counter width in frames; used only with blink compiled in.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures vals/dp_in/blink_mask into staging.
- vals  in  4*DIGITS  digit i value at [4i+3:4i], hex 0..F.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blink_mask  in  DIGITS  1 = digit blinks (ignored without blink feature).
- lz_blank  in  1  live; 1 = suppress leading zeros.
- bright  in  3  live; duty level, on-time = (bright+1)/8 of each slot.
- seg  out  7  {g,f,e,d,c,b,a}, active low, registered.
- dp  out  1  active low, registered.
- an  out  DIGITS  anode enables, active low, one-hot-low, registered.
- pending  out  1  staged data is waiting for commit.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Prescaler `pre` (DIV_W bits) increments every clock. Digit index `idx` advances when `pre` is all ones and wraps from DIGITS-1 to 0, including when DIGITS is not a power of two.
- Frame boundary: `pre` is all ones and `idx` == DIGITS-1.
- Staging: `load` captures vals, dp_in and blink_mask, and sets pending=1. A `load` while pending=1 overwrites the staging registers; the last load wins.
- Commit: at a frame boundary with pending=1, staging is copied to the display registers and pending is cleared.
  - If `load` arrives in the same cycle as a commit, staging takes the new data, display takes the previously staged data, and pending stays 1.
  - If pending=0 at the boundary, nothing is committed.
- Decode is hex from the display registers:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000.
  - A → 0001000, b → 0000011, C → 1000110, d → 0100001, E → 0000110, F → 0001110.
- Leading-zero blanking: with lz_blank=1, digit k is blanked if it and every digit above it are 0. Digit 0 is never blanked.
- Brightness: the current anode is driven only while `pre[DIV_W-1:DIV_W-3]` <= bright. bright=7 gives full on.
- Blanked or PWM-off slot: an = all ones, seg = 1111111, dp = 1.
- frame_done is asserted in the cycle after a frame boundary, every frame, independent of pending.

## Timing
- Reset values:
  - an all ones, seg 1111111, dp 1.
  - pending 0, frame_done 0.
  - pre 0, idx 0, blink counter 0.
  - Staging and display registers: values 0, dp 0, blink_mask 0.
- Output latency: seg/dp/an reflect the `pre`/`idx` state of the previous cycle (one register stage).
- pending rises the cycle after `load` and falls the cycle after the commit edge.
- A committed value appears on the pins no later than the first slot of the next frame; worst-case load-to-visible latency is DIGITS*2^DIV_W + 1 clocks.
- Reset mid-frame: all state returns to reset values immediately; staged data is discarded.

## Configuration
- SSD_BLINK_EN defined:
  - A BLINK_W-bit counter increments on every frame boundary.
  - While the counter MSB is 1, digits whose committed blink_mask bit is 1 are blanked.
- SSD_BLINK_EN undefined:
  - The counter and the blink_mask staging/display registers are not built.
  - blink_mask is ignored and no digit ever blinks.

## Test plan
All scenarios use DIGITS=4, DIV_W=4.
- Reset release → an=1111, seg=1111111; after 1 clock an=1110, seg=1000000 (digit 0 shows "0"); an rotates every 16 clocks to 1101, 1011, 0111; frame_done pulses every 64 clocks.
- Load vals=0x00A5 with lz_blank=1 → pending=1 until the frame boundary. Next frame: digit0 shows 0010010 and digit1 shows 0001000. Digits 2 and 3 keep an high.
- Two loads in one frame (0x1234, then 0x5678), plus a load coinciding with the commit edge → only 0x5678 is displayed; 0x1234 never appears; the edge-coincident load leaves pending=1.
- bright=0 → each anode low for 2 of 16 clocks per slot. bright=7 → low for all 16.
- DIGITS=5 instance → idx wraps 4→0 and the frame is 80 clocks.
- With SSD_BLINK_EN, BLINK_W=2, blink_mask=0001 → digit 0 is dark for 2 of every 4 frames while the other digits stay lit. Without the macro, digit 0 is never dark.
